// File: rtl/ps2_key_state.sv
// PS/2 scan-code decoder: tracks make/break and E0-extended prefixes and keeps
// registered held-key bitmaps for two players plus the last received byte.
module ps2_key_state #(
    parameter int unsigned PREFIX_TIMEOUT = 25000,
    parameter int unsigned TO_W           = 15
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic [7:0] Scan_Code_In,
    input  logic       Scan_Valid_In,
    output logic [4:0] p1keys,
    output logic [4:0] p2keys,
    output logic [7:0] Last_Code_Out,
    output logic       Prefix_Drop_Out
);

    localparam int unsigned KEY_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [KEY_W-1:0]  p1_nxt, p2_nxt;
    logic [KEY_W-1:0]  norm_p1, norm_p2, ext_p2;
    logic [7:0]        last_nxt;
    logic              drop_nxt;
    logic              expire;

    // Key map: one-hot bit per player, normal and extended contexts kept apart
    always_comb begin
        norm_p1 = '0;
        norm_p2 = '0;
        ext_p2  = '0;
        case (Scan_Code_In)
            8'h1D:   norm_p1 = 5'b00001;
            8'h1C:   norm_p1 = 5'b00010;
            8'h23:   norm_p1 = 5'b00100;
            8'h1B:   norm_p1 = 5'b01000;
            8'h29:   norm_p1 = 5'b10000;
            8'h5A:   norm_p2 = 5'b10000;
            default: ;
        endcase
        case (Scan_Code_In)
            8'h75:   ext_p2 = 5'b00001;
            8'h6B:   ext_p2 = 5'b00010;
            8'h74:   ext_p2 = 5'b00100;
            8'h72:   ext_p2 = 5'b01000;
            default: ;
        endcase
    end

    assign expire = (state != IDLE) && (to_cnt == TO_W'(PREFIX_TIMEOUT));

    // Next-state, bitmap update and prefix timeout
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        p1_nxt     = p1keys;
        p2_nxt     = p2keys;
        last_nxt   = Last_Code_Out;
        drop_nxt   = 1'b0;

        if (Scan_Valid_In) begin
            last_nxt   = Scan_Code_In;
            to_cnt_nxt = '0;
            if (Scan_Code_In == 8'hAA || Scan_Code_In == 8'hFC) begin
                p1_nxt    = '0;
                p2_nxt    = '0;
                state_nxt = IDLE;
            end else if (Scan_Code_In == 8'h00 || Scan_Code_In == 8'hFF) begin
                state_nxt = IDLE;
            end else if (Scan_Code_In == 8'hE0) begin
                state_nxt = EXT;
            end else if (Scan_Code_In == 8'hF0) begin
                state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
                case (state)
                    IDLE: begin
                        p1_nxt = p1keys | norm_p1;
                        p2_nxt = p2keys | norm_p2;
                    end
                    BRK: begin
                        p1_nxt = p1keys & ~norm_p1;
                        p2_nxt = p2keys & ~norm_p2;
                    end
                    EXT:     p2_nxt = p2keys | ext_p2;
                    EXT_BRK: p2_nxt = p2keys & ~ext_p2;
                    default: ;
                endcase
            end
        end else if (state != IDLE) begin
            if (expire) begin
                state_nxt  = IDLE;
                drop_nxt   = 1'b1;
                to_cnt_nxt = '0;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
        end else begin
            to_cnt_nxt = '0;
        end
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state           <= IDLE;
            to_cnt          <= '0;
            p1keys          <= '0;
            p2keys          <= '0;
            Last_Code_Out   <= 8'h00;
            Prefix_Drop_Out <= 1'b0;
        end else begin
            state           <= state_nxt;
            to_cnt          <= to_cnt_nxt;
            p1keys          <= p1_nxt;
            p2keys          <= p2_nxt;
            Last_Code_Out   <= last_nxt;
            Prefix_Drop_Out <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_key_state.sv
// Directed plus randomized bench for ps2_key_state against a prefix-flag
// reference model of the scan-code rules.
module tb_ps2_key_state;

    localparam int unsigned T = 25000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code;
    logic       valid;
    logic [4:0] p1keys, p2keys;
    logic [7:0] last_code;
    logic       drop;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit         m_ext, m_brk;
    int         m_age;
    logic [4:0] m_p1, m_p2;
    logic [7:0] m_last;
    logic       m_drop;

    ps2_key_state #(.PREFIX_TIMEOUT(T), .TO_W(15)) dut (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .Scan_Code_In    (code),
        .Scan_Valid_In   (valid),
        .p1keys          (p1keys),
        .p2keys          (p2keys),
        .Last_Code_Out   (last_code),
        .Prefix_Drop_Out (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("p1keys", {3'b0, p1keys}, {3'b0, m_p1});
        check("p2keys", {3'b0, p2keys}, {3'b0, m_p2});
        check("last",   last_code, m_last);
        check("drop",   {7'b0, drop}, {7'b0, m_drop});
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_age = 0;
        m_p1 = '0; m_p2 = '0; m_last = 8'h00; m_drop = 1'b0;
    endtask

    // returns {p2 mask, p1 mask} for a code in the given context
    function automatic logic [9:0] key_of(input bit ext, input logic [7:0] c);
        logic [9:0] r;
        r = '0;
        if (!ext) begin
            if (c == 8'h1D) r[0] = 1'b1;
            if (c == 8'h1C) r[1] = 1'b1;
            if (c == 8'h23) r[2] = 1'b1;
            if (c == 8'h1B) r[3] = 1'b1;
            if (c == 8'h29) r[4] = 1'b1;
            if (c == 8'h5A) r[9] = 1'b1;
        end else begin
            if (c == 8'h75) r[5] = 1'b1;
            if (c == 8'h6B) r[6] = 1'b1;
            if (c == 8'h74) r[7] = 1'b1;
            if (c == 8'h72) r[8] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step(input logic v, input logic [7:0] c);
        logic [9:0] k;
        m_drop = 1'b0;
        if (v) begin
            m_last = c;
            m_age  = 0;
            if (c == 8'hAA || c == 8'hFC) begin
                m_p1 = '0; m_p2 = '0; m_ext = 0; m_brk = 0;
            end else if (c == 8'h00 || c == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else if (c == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else begin
                k = key_of(m_ext, c);
                if (m_brk) begin
                    m_p1 = m_p1 & ~k[4:0];
                    m_p2 = m_p2 & ~k[9:5];
                end else begin
                    m_p1 = m_p1 | k[4:0];
                    m_p2 = m_p2 | k[9:5];
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            // a pending prefix has waited T cycles already: drop it now
            if (m_age == T) begin
                m_ext = 0; m_brk = 0; m_age = 0; m_drop = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] c);
        valid = v;
        code  = c;
        @(posedge clk);
        model_step(v, c);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] c);
        tick(1'b1, c);
    endtask

    initial begin
        logic [7:0] pool [16];
        logic [7:0] c;
        pool = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h29, 8'h5A, 8'h75, 8'h6B,
                 8'h74, 8'h72, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'h00};

        rst_n = 1'b0; valid = 1'b0; code = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // make / break of W
        send(8'h1D);
        send(8'hF0); send(8'h1D);
        // extended P2 Up, then Space, then extended break
        send(8'hE0); send(8'h75); send(8'h29);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h29);
        // extended 1D must not touch P1 Up; typematic repeat
        send(8'hE0); send(8'h1D);
        send(8'h1D); send(8'h1D); send(8'h1D);
        send(8'hF0); send(8'h1D);
        // hold several keys then self-test clears everything
        send(8'h1C); send(8'h23); send(8'h5A); send(8'hE0); send(8'h72);
        send(8'hAA);
        // malformed and overrun sequences
        send(8'h1B); send(8'hF0); send(8'hE0); send(8'h72); send(8'hFF); send(8'hF0); send(8'h00);
        send(8'h1B);
        send(8'hFC);

        // prefix timeout: F0 then idle until it is dropped, next 1B is a make
        send(8'hF0);
        repeat (T + 1) tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        send(8'h1B);
        // strobe lands on the expiry cycle: no drop, byte is a break
        send(8'hF0);
        repeat (T) tick(1'b0, 8'h00);
        send(8'h1B);
        tick(1'b0, 8'h00);

        // async reset mid E0 F0 with keys held
        send(8'h29); send(8'h5A); send(8'hE0); send(8'hF0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        valid = 1'b1; code = 8'h1D;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        valid = 1'b0;
        rst_n = 1'b1;
        send(8'h75);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) c = 8'($urandom);
            else c = pool[$urandom_range(0, 15)];
            tick(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_state.md
Name: ps2_key_state

Overview:
- Converts the raw PS/2 scan-code byte stream (make/break, E0-extended) into registered held-key bitmaps for both players.
- Sits between the PS/2 byte receiver and VGA_Draw.
- Its p1keys/p2keys outputs drive VGA_Draw's Up/Left/Right/Down/Fire inputs directly.
- Also supplies the last accepted code for the debug LED banks.

Parameters:
- PREFIX_TIMEOUT, 25000, Master_Clock_In cycles a pending E0/F0 prefix may wait for its next byte before being discarded (1 ms at 25 MHz).
- TO_W, 15, counter width for PREFIX_TIMEOUT; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- Master_Clock_In  input  1  system clock (25 MHz domain).
- Reset_N_In  input  1  asynchronous, active-low reset.
- Scan_Code_In  input  8  byte from PS/2 receiver; valid only when Scan_Valid_In=1.
- Scan_Valid_In  input  1  single-cycle strobe, one per received byte.
- p1keys  output  5  P1 held keys: [0]Up [1]Left [2]Right [3]Down [4]Fire.
- p2keys  output  5  P2 held keys, same bit order.
- Last_Code_Out  output  8  last byte accepted (any value), for the debug LEDs.
- Prefix_Drop_Out  output  1  one-cycle pulse when a prefix times out.

Behaviour:
- Reset (async assert, sync release): p1keys=0, p2keys=0, Last_Code_Out=8'h00, Prefix_Drop_Out=0, FSM=IDLE, timeout counter=0.
- All outputs are registered. A byte strobed in cycle N is reflected on the outputs in cycle N+1. Latency is 1 cycle; the block accepts back-to-back strobes.
- Key map, normal (unprefixed) codes:
  - P1: 1D=W→Up, 1C=A→Left, 23=D→Right, 1B=S→Down, 29=Space→Fire.
  - P2: 5A=Enter→Fire.
- Key map, extended (E0-prefixed) codes, all P2: 75→Up, 6B→Left, 74→Right, 72→Down.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions on each Scan_Valid_In:
  - IDLE: E0→EXT; F0→BRK; else apply normal make (set bit), stay IDLE.
  - BRK: F0→BRK; E0→EXT (malformed sequence, restart); else apply normal break (clear bit), go IDLE.
  - EXT: E0→EXT; F0→EXT_BRK; else apply extended make, go IDLE.
  - EXT_BRK: E0→EXT; F0→EXT_BRK; else apply extended break, go IDLE.
- Unmapped codes: no bitmap change, but the prefix is still consumed (FSM returns to IDLE).
- The same code in normal vs extended context is distinct. E0 1D (not mapped) must not touch P1 Up.
- Make of an already-held key and break of a released key are no-ops (typematic repeat safe).
- Special bytes, handled in any state:
  - AA (self-test pass) or FC (error): clear both bitmaps, go IDLE.
  - 00 or FF (overrun): go IDLE, no bitmap change.
- Last_Code_Out updates on every strobe, including prefixes and special bytes.
- Prefix timeout:
  - Counter clears on every strobe and counts while FSM≠IDLE.
  - On reaching PREFIX_TIMEOUT with no strobe: FSM→IDLE, Prefix_Drop_Out=1 for one cycle, bitmaps unchanged.
  - A strobe in the same cycle as expiry wins: the byte is processed and no drop pulse is issued.
- Counter saturates and never wraps. In IDLE it holds 0.
- Scan_Valid_In is ignored while Reset_N_In=0. Reset mid-sequence discards any pending prefix.
- Both players may hold any combination of keys simultaneously. Opposing directions are passed through; VGA_Draw arbitrates.

Test Plan:
- Reset then strobe 1D → p1keys=5'b00001 next cycle, Last_Code_Out=1D. Strobe F0,1D → p1keys=0, FSM IDLE.
- Strobe E0,75 then 29 → p2keys=5'b00001, p1keys=5'b10000. Strobe E0,F0,75 → p2keys=0, p1keys unchanged.
- Strobe E0,1D → p1keys unchanged (0). Strobe 1D,1D,1D (repeat) then F0,1D → p1keys=0 after the single break.
- Hold 1C,23,5A,E0 72, then strobe AA → p1keys=0 and p2keys=0 the following cycle.
- Strobe F0, then idle 25000 cycles → Prefix_Drop_Out pulses once, FSM IDLE. Next strobe 1B sets Down (make, not break). Repeat with the strobe landing on the expiry cycle → no pulse, byte treated as break.
- Assert Reset_N_In low mid-way through E0,F0 with keys held → outputs clear immediately (async). After release, strobe 75 → treated as a normal code (unmapped), p2keys=0.
